// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: bus length codes, RISC-V funct3
// values, exception cause codes and FSM state encoding.
// No logic; imported by lsu_align and load_store_unit.
package load_store_unit_pkg;

    // data_bus len encodings
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // RISC-V load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Exception cause codes reported on resp_cause
    localparam logic [3:0] CAUSE_NONE           = 4'd0;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: classifies an access (misaligned or illegal funct3), picks the
// bus length, and sign/zero-extends right-justified bus read data.
// Purely combinational, zero latency, no backpressure.
// Ports: funct3_i/store_i/ea_lo_i in; bus_read_i in; misalign_o, len_o, load_data_o out.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic            store_i,
    input  logic [1:0]      ea_lo_i,
    input  logic [XLEN-1:0] bus_read_i,
    output logic            misalign_o,
    output logic [1:0]      len_o,
    output logic [XLEN-1:0] load_data_o
);

    // Illegal encodings are folded into the misaligned flag: the unsigned
    // variants do not exist for stores, and 011/110/111 are never legal.
    always_comb begin
        misalign_o  = 1'b0;
        len_o       = LEN_B;
        load_data_o = bus_read_i;
        case (funct3_i)
            F3_B: begin
                len_o       = LEN_B;
                load_data_o = {{(XLEN-8){bus_read_i[7]}}, bus_read_i[7:0]};
            end
            F3_BU: begin
                len_o       = LEN_B;
                load_data_o = {{(XLEN-8){1'b0}}, bus_read_i[7:0]};
                misalign_o  = store_i;
            end
            F3_H: begin
                len_o       = LEN_H;
                load_data_o = {{(XLEN-16){bus_read_i[15]}}, bus_read_i[15:0]};
                misalign_o  = ea_lo_i[0];
            end
            F3_HU: begin
                len_o       = LEN_H;
                load_data_o = {{(XLEN-16){1'b0}}, bus_read_i[15:0]};
                misalign_o  = ea_lo_i[0] | store_i;
            end
            F3_W: begin
                len_o       = LEN_W;
                load_data_o = bus_read_i;
                misalign_o  = (ea_lo_i != 2'b00);
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data_bus: computes ea, checks alignment,
// drives the bus for BUS_LATENCY cycles, returns a tagged extended response.
// Latency: BUS_LATENCY+1 cycles (1 for misaligned/illegal); one request in flight,
// req_ready only in IDLE, response held until resp_valid & resp_ready.
// Ports: req_* from execute, resp_* to writeback, bus_* to/from data_bus.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int BUS_LATENCY = 1,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_base,
    input  logic [11:0]     req_offset,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_exc,
    output logic [3:0]      resp_cause,
    output logic            bus_rw,
    output logic [1:0]      bus_len,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_write,
    input  logic [XLEN-1:0] bus_read,
    input  logic            bus_exception
);

    localparam logic [3:0] LAT = 4'(BUS_LATENCY);

    lsu_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [1:0]      len_q, len_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            exc_q, exc_d;
    logic [3:0]      cause_q, cause_d;

    logic            is_idle;
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] wdata_masked;
    logic [XLEN-1:0] load_data;
    logic            bad;
    logic [1:0]      len;

    assign is_idle = (state_q == ST_IDLE);
    assign ea      = req_base + {{(XLEN-12){req_offset[11]}}, req_offset};

    // Store data is right-justified with unused upper bits cleared; loads
    // carry no write data at all so the bus never sees stale operands.
    always_comb begin
        wdata_masked = '0;
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00:   wdata_masked = {{(XLEN-8){1'b0}}, req_wdata[7:0]};
                2'b01:   wdata_masked = {{(XLEN-16){1'b0}}, req_wdata[15:0]};
                default: wdata_masked = req_wdata;
            endcase
        end
    end

    // One classifier/extender shared by both phases: in IDLE it judges the
    // incoming request, during ACCESS it extends read data for the latched op.
    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i    (is_idle ? req_funct3 : funct3_q),
        .store_i     (is_idle ? req_store  : store_q),
        .ea_lo_i     (ea[1:0]),
        .bus_read_i  (bus_read),
        .misalign_o  (bad),
        .len_o       (len),
        .load_data_o (load_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        exc_d    = exc_q;
        cause_d  = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    rd_d     = req_rd;
                    wdata_d  = wdata_masked;
                    if (bad) begin
                        // Bus address/length stay untouched: the bus is never driven.
                        state_d = ST_RESP;
                        exc_d   = 1'b1;
                        cause_d = req_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = LAT;
                        addr_d  = ea;
                        len_d   = len;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd1) begin
                    // Final bus cycle: read data and exception are sampled on this edge.
                    state_d = ST_RESP;
                    if (bus_exception) begin
                        exc_d   = 1'b1;
                        cause_d = store_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                        rdata_d = '0;
                    end else begin
                        exc_d   = 1'b0;
                        cause_d = CAUSE_NONE;
                        rdata_d = store_q ? '0 : load_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            len_q    <= LEN_B;
            wdata_q  <= '0;
            rd_q     <= '0;
            rdata_q  <= '0;
            exc_q    <= 1'b0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            rdata_q  <= rdata_d;
            exc_q    <= exc_d;
            cause_q  <= cause_d;
        end
    end

    // bus_rw and bus_write decode straight from state so a reset drops them
    // the same instant; address and length simply hold their last value.
    assign req_ready  = is_idle;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rd    = rd_q;
    assign resp_data  = rdata_q;
    assign resp_exc   = exc_q;
    assign resp_cause = cause_q;
    assign bus_rw     = (state_q == ST_ACCESS) & store_q;
    assign bus_len    = len_q;
    assign bus_addr   = addr_q;
    assign bus_write  = (state_q == ST_ACCESS) ? wdata_q : '0;

endmodule
